// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the fetch/load-store memory port arbiter
package mem_port_arbiter_pkg;

    localparam int DATA_W  = 32;
    localparam int WMASK_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    typedef enum logic {
        ID_IF = 1'b0,
        ID_LS = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_port_arbiter_arb_pick2.sv
// rtl/mem_port_arbiter_arb_pick2.sv - two-requester tie-break; ARB_ROUND_ROBIN_EN selects round-robin over fixed ls priority
module arb_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic    req_if_i,
    input  logic    req_ls_i,
    input  req_id_e last_i,
    output req_id_e winner_o
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_comb begin
        winner_o = ID_IF;
        if (req_ls_i && !req_if_i) begin
            winner_o = ID_LS;
        end else if (req_ls_i && req_if_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Hand the tie to whoever lost last time.
            winner_o = (last_i == ID_LS) ? ID_IF : ID_LS;
`else
            winner_o = ID_LS;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter of fetch and load/store onto one memory port (ARB_ROUND_ROBIN_EN: round-robin ties)
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               if_req,
    input  logic [ADDR_W-1:0]  if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [DATA_W-1:0]  if_rdata,

    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [ADDR_W-1:0]  ls_addr,
    input  logic [DATA_W-1:0]  ls_wdata,
    input  logic [WMASK_W-1:0] ls_wmask,
    output logic               ls_gnt,
    output logic               ls_rvalid,
    output logic [DATA_W-1:0]  ls_rdata,

    output logic               mem_valid,
    input  logic               mem_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic [WMASK_W-1:0] mem_wmask,
    input  logic               mem_rvalid,
    input  logic [DATA_W-1:0]  mem_rdata,

    output logic               busy
);

    state_e             state_q;
    req_id_e            id_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [WMASK_W-1:0] wmask_q;
    logic [DATA_W-1:0]  if_rdata_q;
    logic [DATA_W-1:0]  ls_rdata_q;
    req_id_e            winner_d;
    req_id_e            last_win;
    logic               accept;
    logic               respond;

`ifdef ARB_ROUND_ROBIN_EN
    req_id_e last_q;
    assign last_win = last_q;
`else
    assign last_win = ID_IF;
`endif

    arb_pick2 u_pick (
        .req_if_i (if_req),
        .req_ls_i (ls_req),
        .last_i   (last_win),
        .winner_o (winner_d)
    );

    // Handshake and response pulses are decoded from state so they land in the same cycle as the bus event.
    assign accept  = (state_q == REQ) && mem_ready;
    assign respond = (state_q == WAIT_RSP) && mem_rvalid;

    assign if_gnt    = accept  && (id_q == ID_IF);
    assign ls_gnt    = accept  && (id_q == ID_LS);
    assign if_rvalid = respond && (id_q == ID_IF);
    assign ls_rvalid = respond && (id_q == ID_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign ls_rdata  = ls_rvalid ? mem_rdata : ls_rdata_q;

    assign mem_valid = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            id_q       <= ID_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q     <= ID_IF;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (if_req || ls_req) begin
                        id_q    <= winner_d;
                        state_q <= REQ;
                        if (winner_d == ID_LS) begin
                            we_q    <= ls_we;
                            addr_q  <= ls_addr;
                            wdata_q <= ls_wdata;
                            wmask_q <= ls_we ? ls_wmask : '0;
                        end else begin
                            we_q    <= 1'b0;
                            addr_q  <= if_addr;
                            wdata_q <= '0;
                            wmask_q <= '0;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        state_q <= WAIT_RSP;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q  <= id_q;
`endif
                    end
                end
                WAIT_RSP: begin
                    if (mem_rvalid) begin
                        state_q <= IDLE;
                        if (id_q == ID_LS) ls_rdata_q <= mem_rdata;
                        else               if_rdata_q <= mem_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [31:0] ls_addr, ls_wdata;
    logic [3:0]  ls_wmask;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_valid, mem_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy)
    );

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic        if_req;
        logic        ls_req;
        logic        ls_we;
        logic [31:0] if_addr;
        logic [31:0] ls_addr;
        logic [31:0] ls_wdata;
        logic [3:0]  ls_wmask;
        int          ready_wait;
        int          rsp_wait;
        logic [31:0] rdata;
        logic        exp_ls;
    } vec_t;

    vec_t        vecs[8];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_ls_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_if_rdata = '0;
        exp_ls_rdata = '0;
    endtask

    task automatic check_cmd(input string name, input vec_t v);
        chk({name, "_mem_valid"}, mem_valid, 1'b1);
        chk({name, "_busy"}, busy, 1'b1);
        chk({name, "_mem_we"}, mem_we, v.exp_ls & v.ls_we);
        chk({name, "_mem_addr"}, mem_addr, v.exp_ls ? v.ls_addr : v.if_addr);
        chk({name, "_mem_wmask"}, mem_wmask, (v.exp_ls && v.ls_we) ? v.ls_wmask : 4'h0);
        if (v.exp_ls && v.ls_we) chk({name, "_mem_wdata"}, mem_wdata, v.ls_wdata);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if_req = v.if_req; ls_req = v.ls_req; ls_we = v.ls_we;
        if_addr = v.if_addr; ls_addr = v.ls_addr; ls_wdata = v.ls_wdata; ls_wmask = v.ls_wmask;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("idle_busy", busy, 1'b0);
        chk("idle_mem_valid", mem_valid, 1'b0);
        chk("hold_if_rdata", if_rdata, exp_if_rdata);
        chk("hold_ls_rdata", ls_rdata, exp_ls_rdata);
        @(negedge clk);
        for (int k = 0; k < v.ready_wait; k++) begin
            #1;
            check_cmd("stall", v);
            chk("stall_gnt", {if_gnt, ls_gnt}, 2'b00);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        #1;
        check_cmd("accept", v);
        chk("if_gnt", if_gnt, !v.exp_ls);
        chk("ls_gnt", ls_gnt, v.exp_ls);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int k = 0; k < v.rsp_wait; k++) begin
            #1;
            chk("wait_busy", busy, 1'b1);
            chk("wait_rvalid", {if_rvalid, ls_rvalid, if_gnt, ls_gnt}, 4'b0000);
            @(negedge clk);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = v.rdata;
        #1;
        chk("if_rvalid", if_rvalid, !v.exp_ls);
        chk("ls_rvalid", ls_rvalid, v.exp_ls);
        if (v.exp_ls) exp_ls_rdata = v.rdata;
        else          exp_if_rdata = v.rdata;
        chk("rsp_if_rdata", if_rdata, exp_if_rdata);
        chk("rsp_ls_rdata", ls_rdata, exp_ls_rdata);
    endtask

    initial begin
        // if, ls, we, if_addr, ls_addr, wdata, wmask, ready_wait, rsp_wait, rdata, exp_ls
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h80000000, 32'h0, 32'h0, 4'h0, 0, 1, 32'h00100093, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h80001000, 32'hDEADBEEF, 4'b0011, 3, 0, 32'h00000000, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h80002004, 32'h11111111, 4'hF, 1, 2, 32'hCAFEF00D, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h00000010, 32'h0, 32'h0, 4'h0, 0, 0, 32'h00000013, 1'b0};
        for (int i = 4; i < 8; i++)
            vecs[i] = '{1'b1, 1'b1, 1'b0, 32'h200 + i * 4, 32'h100 + i * 4, 32'h0, 4'hF, 0, 0,
                        32'hA5A50000 + i, RR ? ((i % 2) == 0) : 1'b1};

        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = '0; ls_addr = '0; ls_wdata = '0; ls_wmask = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_gnt_rvalid", {if_gnt, ls_gnt, if_rvalid, ls_rvalid}, 4'b0000);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_ls_rdata", ls_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_we_wmask", {mem_we, mem_wmask}, 5'h0);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (i == 4) do_reset();
            run_vec(vecs[i]);
        end

        // mem_rvalid seen in IDLE, in REQ and alongside the accepting mem_ready must all be dropped.
        @(negedge clk);
        if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h80003000;
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1;
        chk("idle_rvalid_ignored", {if_rvalid, ls_rvalid}, 2'b00);
        @(negedge clk);
        #1;
        chk("req_busy", busy, 1'b1);
        chk("req_rvalid_ignored", ls_rvalid, 1'b0);
        mem_ready = 1'b1;
        #1;
        chk("same_cycle_gnt", ls_gnt, 1'b1);
        chk("same_cycle_rvalid_ignored", ls_rvalid, 1'b0);
        @(negedge clk);
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("wait_rsp_busy", busy, 1'b1);
        chk("wait_rsp_no_valid", mem_valid, 1'b0);
        chk("wait_rsp_ls_rdata_hold", ls_rdata, exp_ls_rdata);
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h5EED5EED;
        #1;
        chk("late_ls_rvalid", ls_rvalid, 1'b1);
        chk("late_ls_rdata", ls_rdata, 32'h5EED5EED);
        @(negedge clk);
        ls_req = 1'b0; mem_rvalid = 1'b0;
        #1;
        chk("after_busy", busy, 1'b0);
        chk("after_ls_rdata_hold", ls_rdata, 32'h5EED5EED);

        // Reset while waiting for a response; the stale response must vanish.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h80000040;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("abandon_if_gnt", if_gnt, 1'b1);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        chk("abandon_wait_busy", busy, 1'b1);
        rst = 1'b0; if_req = 1'b0;
        @(negedge clk);
        rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stale_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
            chk("stale_busy", busy, 1'b0);
            chk("stale_if_rdata", if_rdata, 32'h0);
            chk("stale_ls_rdata", ls_rdata, 32'h0);
            @(negedge clk);
        end
        mem_rvalid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address width for all address ports; data width fixed at 32.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have if_req  input  1  and if_addr  input  ADDR_W: instruction-fetch read request and word-aligned address.
REQ-005 SHALL have if_gnt  output  1  and if_rvalid  output  1  and if_rdata  output  32: fetch accepted pulse, response-valid pulse, and read data.
REQ-006 SHALL have ls_req  input  1, ls_we  input  1, ls_addr  input  ADDR_W, ls_wdata  input  32, ls_wmask  input  4: load/store request, write flag, address, store data, byte enables.
REQ-007 SHALL have ls_gnt  output  1, ls_rvalid  output  1, ls_rdata  output  32: load/store accepted pulse, completion pulse (loads and stores), and load data.
REQ-008 SHALL have mem_valid  output  1, mem_ready  input  1: downstream request handshake; transfer when both high on a rising edge.
REQ-009 SHALL have mem_we  output  1, mem_addr  output  ADDR_W, mem_wdata  output  32, mem_wmask  output  4: downstream command fields, valid while mem_valid high.
REQ-010 SHALL have mem_rvalid  input  1, mem_rdata  input  32: downstream completion pulse and read data.
REQ-011 SHALL have busy  output  1: high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT_RSP; at most one outstanding downstream transaction.
REQ-013 IDLE: if any request is pending, latch the winner's id and command fields into registers and go to REQ next cycle; otherwise stay in IDLE.
REQ-014 Arbitration when both if_req and ls_req are high in IDLE is set by REQ-026/REQ-027; when a single request is pending, it wins.
REQ-015 REQ: mem_valid=1 with latched fields; on mem_valid&&mem_ready, pulse the winner's *_gnt for exactly that cycle and go to WAIT_RSP.
REQ-016 REQ: mem_valid SHALL hold and fields SHALL remain stable until mem_ready is seen; there is no timeout.
REQ-017 WAIT_RSP: on mem_rvalid, pulse the winner's *_rvalid for one cycle with *_rdata=mem_rdata, go to IDLE.
REQ-018 mem_rvalid in the same cycle as the accepting mem_ready SHALL be ignored; a response is only accepted in WAIT_RSP.
REQ-019 For a fetch, mem_we=0 and mem_wmask=4'b0000; for a load, mem_wmask=4'b0000; for a store, mem_wmask=ls_wmask.
REQ-020 Requesters SHALL hold req and fields until their *_rvalid; the arbiter samples fields only in IDLE.
REQ-021 Minimum latency: request in IDLE cycle N -> mem_valid in N+1 -> gnt in N+1 if mem_ready -> rvalid at the earliest in N+2; back-to-back throughput is one transaction per 3 cycles.
REQ-022 mem_rvalid while in IDLE or REQ SHALL be ignored, with no output pulse and no state change.
REQ-023 *_rdata SHALL hold the last delivered value between pulses; the non-winner's rvalid and gnt SHALL stay 0.

Reset
REQ-024 On rst=0 at a clock edge: state=IDLE, mem_valid=0, all gnt/rvalid=0, busy=0, latched fields and rdata=0, last-winner=fetch.
REQ-025 Reset mid-transaction SHALL abandon it; a late mem_rvalid after reset is dropped per REQ-022.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: on a tie, grant the requester that did not win the previous transaction; last-winner updates at each grant.
REQ-027 Macro undefined: on a tie, ls always wins (fixed priority), and no last-winner register is built.

Structure
REQ-028 A shared package SHALL hold the FSM state enum (IDLE/REQ/WAIT_RSP), the requester-id type (ID_IF/ID_LS), and the wmask width constant.
REQ-029 The tie-break logic SHALL be a sub-module arb_pick2 (inputs: two reqs and last-winner; output: winner id), containing both macro variants.
REQ-030 The FSM, latches, and response routing SHALL stay in mem_port_arbiter.

Verification
REQ-031 Fetch only: if_req=1, if_addr=0x80000000, mem_ready=1, mem_rvalid 2 cycles later with rdata=0x00100093 -> if_gnt pulse, if_rvalid pulse, if_rdata=0x00100093, busy back to 0.
REQ-032 Store: ls_we=1, addr=0x80001000, wdata=0xDEADBEEF, wmask=4'b0011 -> mem_we=1 and matching fields held across 3 mem_ready=0 cycles; ls_rvalid on ack.
REQ-033 Tie with macro undefined: both reqs held for 4 transactions -> ls wins all 4; if_gnt never pulses.
REQ-034 Tie with ARB_ROUND_ROBIN_EN: both reqs held -> winners alternate LS, IF, LS, IF, starting with LS.
REQ-035 Reset in WAIT_RSP, then mem_rvalid=1 with rdata=0x12345678 -> no rvalid pulse, state IDLE, rdata outputs 0.
